hex_display_sched: RTL

Time-multiplexing scheduler that shares the six seven-segment displays (HEX5..HEX0) between several requesters, such as the score, debug and status producers. It round-robins between active requesters with a guaranteed minimum dwell time per owner, and blanks the displays when nobody requests. The seven-segment encoding is produced internally from registered nibbles, so the block drives the board HEX pins directly.

---
 rtl/hex_display_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/hex_display_sched.sv
// Round-robin owner of the six HEX displays with minimum dwell per owner; blanks when idle.
// Optional HEX_LZB_EN: blank leading-zero digits HEX5..HEX1 in the registered output stage.
module hex_display_sched #(
    parameter int N_REQ = 2,
    parameter int DWELL = 50_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*24-1:0]  value,
    output logic [N_REQ-1:0]     grant,
    output logic [6:0]           HEX0,
    output logic [6:0]           HEX1,
    output logic [6:0]           HEX2,
    output logic [6:0]           HEX3,
    output logic [6:0]           HEX4,
    output logic [6:0]           HEX5
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] DMAX    = CW'(DWELL - 1);
    localparam logic [PW-1:0] PTR_RST = PW'(N_REQ - 1);
    localparam logic [6:0]    BLANK   = 7'h7F;

    typedef enum logic {IDLE, SHOW} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [CW-1:0]   dwell, dwell_n;
    logic [N_REQ-1:0] grant_n;
    logic [6:0]      hex [6];
    logic [6:0]      hex_n [6];

    logic            any_found, other_found;
    logic [PW-1:0]   any_idx, other_idx, scan_idx;
    logic [3:0]      nib;
    logic            lead;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Scan ptr+1, ptr+2, ... modulo N_REQ; "other" excludes the current owner at ptr.
    always_comb begin
        any_found   = 1'b0;
        any_idx     = ptr;
        other_found = 1'b0;
        other_idx   = ptr;
        scan_idx    = ptr;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = PW'((int'(ptr) + k) % N_REQ);
            if (!any_found && req[scan_idx]) begin
                any_found = 1'b1;
                any_idx   = scan_idx;
            end
            if (k < N_REQ && !other_found && req[scan_idx]) begin
                other_found = 1'b1;
                other_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= PTR_RST;
            dwell <= '0;
            grant <= '0;
            for (int d = 0; d < 6; d++) hex[d] <= BLANK;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            dwell <= dwell_n;
            grant <= grant_n;
            for (int d = 0; d < 6; d++) hex[d] <= hex_n[d];
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        dwell_n = dwell;
        case (state)
            IDLE: begin
                if (any_found) begin
                    state_n = SHOW;
                    ptr_n   = any_idx;
                    dwell_n = '0;
                end
            end
            default: begin
                if (!req[ptr]) begin
                    dwell_n = '0;
                    if (other_found) ptr_n = other_idx;
                    else             state_n = IDLE;
                end else if (dwell == DMAX && other_found) begin
                    ptr_n   = other_idx;
                    dwell_n = '0;
                end else if (dwell != DMAX) begin
                    dwell_n = dwell + 1'b1;
                end
            end
        endcase
    end

    // Outputs are decoded from the next owner so grant and HEX register on the same edge.
    always_comb begin
        grant_n = '0;
        nib     = '0;
        lead    = 1'b1;
        for (int d = 0; d < 6; d++) hex_n[d] = BLANK;
        if (state_n == SHOW) begin
            grant_n[ptr_n] = 1'b1;
            for (int d = 5; d >= 0; d--) begin
                nib      = value[24*int'(ptr_n) + 4*d +: 4];
                hex_n[d] = seg7(nib);
`ifdef HEX_LZB_EN
                if (d > 0 && lead && nib == 4'h0) hex_n[d] = BLANK;
                else                              lead = 1'b0;
`else
                lead = 1'b0;
`endif
            end
        end
    end

    assign HEX0 = hex[0];
    assign HEX1 = hex[1];
    assign HEX2 = hex[2];
    assign HEX3 = hex[3];
    assign HEX4 = hex[4];
    assign HEX5 = hex[5];

endmodule
